multicycle_controller: RTL

FSM that sequences the CPU datapath as a multi-cycle machine: FETCH, DECODE, EXEC, MEM and WB over a single shared memory port with a req/ready handshake. It takes the decoded op_code/func and the ALU zero flag, and drives every datapath enable and mux select: PC write, IR write, register write, memory strobes, ALU command and source selects. It also detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, drives datapath strobes/selects, traps illegal ops and memory timeouts.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       op_code,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_is_instr,
   output logic             mem_write,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic [1:0]       wa_src,
   output logic [1:0]       wd_src,
   output logic             ALU_src,
   output logic [2:0]       ALU_op,
   output logic [2:0]       state,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned TO_W = 8;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   state_t            state_q;
   state_t            next_state;
   logic              fault_q;
   logic [1:0]        fault_code_q;
   logic [1:0]        fault_set;
   logic              retire;
   logic [CNT_W-1:0]  retired_q;
   logic [TO_W-1:0]   to_cnt;

   // Instruction classification from the current IR fields
   logic is_r, r_add, r_sub, r_slt, r_jr;
   logic is_lw, is_sw, is_addi, is_xori, is_beq, is_bne, is_j, is_jal, legal;

   assign is_r    = (op_code == OP_RTYPE);
   assign r_add   = is_r && (func == FN_ADD);
   assign r_sub   = is_r && (func == FN_SUB);
   assign r_slt   = is_r && (func == FN_SLT);
   assign r_jr    = is_r && (func == FN_JR);
   assign is_lw   = (op_code == OP_LW);
   assign is_sw   = (op_code == OP_SW);
   assign is_addi = (op_code == OP_ADDI);
   assign is_xori = (op_code == OP_XORI);
   assign is_beq  = (op_code == OP_BEQ);
   assign is_bne  = (op_code == OP_BNE);
   assign is_j    = (op_code == OP_J);
   assign is_jal  = (op_code == OP_JAL);
   assign legal   = r_add || r_sub || r_slt || r_jr || is_lw || is_sw || is_addi ||
                    is_xori || is_beq || is_bne || is_j || is_jal;

   assign state      = state_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign retired    = retired_q;

   // Next-state and datapath control
   always_comb begin
      mem_req      = 1'b0;
      mem_is_instr = 1'b0;
      mem_write    = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      reg_write    = 1'b0;
      wa_src       = 2'd0;
      wd_src       = 2'd0;
      ALU_src      = 1'b0;
      ALU_op       = 3'd0;
      next_state   = state_q;
      retire       = 1'b0;
      fault_set    = 2'd0;

      case (state_q)
         S_FETCH: begin
            if (run) begin
               mem_req      = 1'b1;
               mem_is_instr = 1'b1;
               if (mem_ready) begin
                  ir_we      = 1'b1;
                  pc_we      = 1'b1;
                  next_state = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            if (!legal) begin
               next_state = S_FAULT;
               fault_set  = 2'd1;
            end else if (is_j || is_jal) begin
               pc_we      = 1'b1;
               pc_src     = 2'd2;
               retire     = 1'b1;
               next_state = S_FETCH;
               if (is_jal) begin
                  reg_write = 1'b1;
                  wa_src    = 2'd2;
                  wd_src    = 2'd2;
               end
            end else if (r_jr) begin
               pc_we      = 1'b1;
               pc_src     = 2'd3;
               retire     = 1'b1;
               next_state = S_FETCH;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_r) begin
               ALU_op     = r_sub ? 3'd1 : (r_slt ? 3'd3 : 3'd0);
               next_state = S_WB;
            end else if (is_lw || is_sw) begin
               ALU_src    = 1'b1;
               next_state = S_MEM;
            end else if (is_addi || is_xori) begin
               ALU_src    = 1'b1;
               ALU_op     = is_xori ? 3'd2 : 3'd0;
               next_state = S_WB;
            end else begin
               ALU_op     = 3'd1;
               if ((is_beq && zero) || (is_bne && !zero)) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd1;
               end
               retire     = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            ALU_src   = 1'b1;
            mem_write = is_sw;
            if (mem_ready) begin
               if (is_sw) begin
                  retire     = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
            if (is_r) begin
               wa_src = 2'd1;
            end else if (is_lw) begin
               wd_src = 2'd1;
            end else begin
               ALU_src = 1'b1;
               ALU_op  = is_xori ? 3'd2 : 3'd0;
            end
         end
         S_FAULT: begin
            next_state = S_FAULT;
         end
         default: begin
            next_state = S_FETCH;
         end
      endcase

      // A stalled request that has already waited MEM_TIMEOUT cycles traps; ready wins
      if (mem_req && !mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT))) begin
         next_state = S_FAULT;
         fault_set  = 2'd2;
         retire     = 1'b0;
      end

      if (!reset) begin
         mem_req      = 1'b0;
         mem_is_instr = 1'b0;
         mem_write    = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         pc_src       = 2'd0;
         reg_write    = 1'b0;
         wa_src       = 2'd0;
         wd_src       = 2'd0;
         ALU_src      = 1'b0;
         ALU_op       = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_FETCH;
         fault_q      <= 1'b0;
         fault_code_q <= 2'd0;
         retired_q    <= '0;
         to_cnt       <= '0;
      end else begin
         state_q <= next_state;
         if (fault_set != 2'd0) begin
            fault_q      <= 1'b1;
            fault_code_q <= fault_set;
         end
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
         if (mem_req && !mem_ready && (next_state == state_q)) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule
